// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the sequential
// multiply/divide unit. The pipeline side uses the master modport.
// The unit itself uses the slave modport.
interface muldiv_seq_if;
   // request side
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        rd_hilo;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wd;
   // result / status side
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        dbz;
   logic        stall;

   modport master (
      output start, op, a, b, flush, rd_hilo, hi_we, lo_we, wd,
      input  hi, lo, busy, done, dbz, stall
   );

   modport slave (
      input  start, op, a, b, flush, rd_hilo, hi_we, lo_we, wd,
      output hi, lo, busy, done, dbz, stall
   );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential 32-bit multiply/divide unit with architectural HI/LO registers.
// One result bit per cycle: shift-add multiply, restoring divide. Signed ops
// run on magnitudes and get their sign fixed in a final FIX cycle.
// op encoding: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
module muldiv_seq (
   input  logic         clk,
   input  logic         rst,   // asynchronous, active-low
   muldiv_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t       state_q, state_d;

   // latched operation context
   logic [1:0]   op_q;
   logic [31:0]  am_q;      // |a| for signed ops, raw a otherwise
   logic [31:0]  bm_q;      // |b| for signed ops, raw b otherwise
   logic         sa_q;      // sign bit of raw a
   logic         sb_q;      // sign bit of raw b
   logic [5:0]   cnt_q, cnt_d;
   logic [63:0]  acc_q, acc_d;

   // architectural registers and registered status
   logic [31:0]  hi_q, hi_d;
   logic [31:0]  lo_q, lo_d;
   logic         done_q, done_d;
   logic         dbz_q, dbz_d;

   // FSM outputs / decoded controls
   logic         busy;
   logic         stall;
   logic         start_ok;
   logic         fix_commit;

   // operand conditioning at issue
   logic         in_signed;
   logic         in_div;
   logic [31:0]  a_mag;
   logic [31:0]  b_mag;

   // per-cycle datapath step
   logic         is_div;
   logic         is_signed;
   logic [32:0]  mul_sum;
   logic [32:0]  div_rem_sh;
   logic [32:0]  div_diff;
   logic [63:0]  step_val;

   // sign-fixed result
   logic         div_by_zero;
   logic [63:0]  prod_fix;
   logic [31:0]  quo_fix;
   logic [31:0]  rem_fix;
   logic [31:0]  raw_a;
   logic [31:0]  res_hi;
   logic [31:0]  res_lo;

   assign in_signed = bus.op[0];
   assign in_div    = bus.op[1];
   assign a_mag     = (in_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
   assign b_mag     = (in_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

   assign is_div    = op_q[1];
   assign is_signed = op_q[0];

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush always wins over start and over completion
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.flush) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else if (cnt_q == 6'd31) begin
               // counter reaches 32 on this edge
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM outputs: busy, pipeline stall, issue accept and result commit
   always_comb begin
      busy       = 1'b0;
      stall      = 1'b0;
      start_ok   = 1'b0;
      fix_commit = 1'b0;
      case (state_q)
         S_IDLE: begin
            start_ok = bus.start & ~bus.flush;
         end
         S_RUN: begin
            busy = 1'b1;
         end
         S_FIX: begin
            busy       = 1'b1;
            fix_commit = ~bus.flush;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
      stall = busy & (bus.start | bus.rd_hilo | bus.hi_we | bus.lo_we);
   end

   // One iteration of shift-add multiply or restoring divide.
   // Multiply: acc = {partial product, remaining multiplier bits}.
   // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
   always_comb begin
      mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, am_q} : 33'd0);
      div_rem_sh = acc_q[63:31];
      div_diff   = div_rem_sh - {1'b0, bm_q};
      step_val   = {mul_sum, acc_q[31:1]};
      if (is_div) begin
         if (div_diff[32]) begin
            // trial subtract went negative: restore
            step_val = {div_rem_sh[31:0], acc_q[30:0], 1'b0};
         end else begin
            step_val = {div_diff[31:0], acc_q[30:0], 1'b1};
         end
      end
   end

   // Sign fixup and divide-by-zero substitution applied in FIX
   always_comb begin
      div_by_zero = is_div && (bm_q == 32'd0);
      prod_fix    = acc_q;
      quo_fix     = acc_q[31:0];
      rem_fix     = acc_q[63:32];
      raw_a       = am_q;
      if (is_signed && (sa_q != sb_q)) begin
         prod_fix = 64'd0 - acc_q;
         quo_fix  = 32'd0 - acc_q[31:0];
      end
      if (is_signed && sa_q) begin
         rem_fix = 32'd0 - acc_q[63:32];
         raw_a   = 32'd0 - am_q;
      end
      res_hi = prod_fix[63:32];
      res_lo = prod_fix[31:0];
      if (is_div) begin
         if (div_by_zero) begin
            res_hi = raw_a;
            res_lo = 32'hFFFF_FFFF;
         end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
         end
      end
   end

   // Next values for accumulator and counter
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (start_ok) begin
         acc_d = {32'd0, in_div ? a_mag : b_mag};
         cnt_d = 6'd0;
      end else if (state_q == S_RUN) begin
         acc_d = step_val;
         cnt_d = cnt_q + 6'd1;
      end
   end

   // Next values for HI/LO and the registered completion flags
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      dbz_d  = 1'b0;
      if (fix_commit) begin
         hi_d   = res_hi;
         lo_d   = res_lo;
         done_d = 1'b1;
         dbz_d  = div_by_zero;
      end else if (state_q == S_IDLE) begin
         // direct writes only while idle, including alongside an accepted start
         if (bus.hi_we) begin
            hi_d = bus.wd;
         end
         if (bus.lo_we) begin
            lo_d = bus.wd;
         end
      end
   end

   // Datapath and architectural register update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q   <= 2'd0;
         am_q   <= 32'd0;
         bm_q   <= 32'd0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         cnt_q  <= 6'd0;
         acc_q  <= 64'd0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         if (start_ok) begin
            op_q <= bus.op;
            am_q <= a_mag;
            bm_q <= b_mag;
            sa_q <= bus.a[31];
            sb_q <= bus.b[31];
         end
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= done_d;
         dbz_q  <= dbz_d;
      end
   end

   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.busy  = busy;
   assign bus.done  = done_q;
   assign bus.dbz   = dbz_q;
   assign bus.stall = stall;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a cycle-level reference model computes
// results with plain arithmetic and is compared against the unit on every
// falling edge; literal expectations pin the model on the key cases.
module tb_muldiv_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;

   muldiv_seq_if bus();

   muldiv_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference result {dbz, hi, lo}
   function automatic logic [64:0] ref_result(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] p;
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin
            p = {32'd0, a} * {32'd0, b};
            return {1'b0, p};
         end
         2'b01: begin
            p = 64'(sa * sb);
            return {1'b0, p};
         end
         2'b10: begin
            if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
            return {1'b0, a % b, a / b};
         end
         default: begin
            if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {1'b0, r[31:0], q[31:0]};
         end
      endcase
   endfunction

   // cycle-level model
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic        m_dbz  = 1'b0;
   logic [31:0] m_hi   = 32'd0;
   logic [31:0] m_lo   = 32'd0;
   logic [31:0] p_hi   = 32'd0;
   logic [31:0] p_lo   = 32'd0;
   logic        p_dbz  = 1'b0;
   int          m_left = 0;

   always @(posedge clk or negedge rst) begin
      logic [64:0] r;
      if (!rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_dbz  <= 1'b0;
         m_hi   <= 32'd0;
         m_lo   <= 32'd0;
         m_left <= 0;
      end else begin
         m_done <= 1'b0;
         m_dbz  <= 1'b0;
         if (m_busy) begin
            if (bus.flush) begin
               m_busy <= 1'b0;
            end else if (m_left == 1) begin
               m_busy <= 1'b0;
               m_hi   <= p_hi;
               m_lo   <= p_lo;
               m_done <= 1'b1;
               m_dbz  <= p_dbz;
            end else begin
               m_left <= m_left - 1;
            end
         end else begin
            if (bus.hi_we) m_hi <= bus.wd;
            if (bus.lo_we) m_lo <= bus.wd;
            if (bus.start && !bus.flush) begin
               r = ref_result(bus.op, bus.a, bus.b);
               p_dbz  <= r[64];
               p_hi   <= r[63:32];
               p_lo   <= r[31:0];
               m_busy <= 1'b1;
               m_left <= 33;
            end
         end
      end
   end

   // compare on every falling edge
   always @(negedge clk) begin
      chk("cmp_hi", bus.hi, m_hi);
      chk("cmp_lo", bus.lo, m_lo);
      chk("cmp_busy", {31'd0, bus.busy}, {31'd0, m_busy});
      chk("cmp_done", {31'd0, bus.done}, {31'd0, m_done});
      chk("cmp_stall", {31'd0, bus.stall},
          {31'd0, m_busy & (bus.start | bus.rd_hilo | bus.hi_we | bus.lo_we)});
      if (m_done) chk("cmp_dbz", {31'd0, bus.dbz}, {31'd0, m_dbz});
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Issue in the current cycle (cycle 0), check completion at cycle 34.
   task automatic run_op(input string name, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic exp_dbz);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      cyc();
      bus.start = 1'b0;
      bus.a     = 32'd0;
      bus.b     = 32'd0;
      chk({name, "_busy1"}, {31'd0, bus.busy}, 32'd1);
      repeat (33) cyc();
      chk({name, "_done"}, {31'd0, bus.done}, 32'd1);
      chk({name, "_dbz"}, {31'd0, bus.dbz}, {31'd0, exp_dbz});
      chk({name, "_hi"}, bus.hi, exp_hi);
      chk({name, "_lo"}, bus.lo, exp_lo);
      chk({name, "_busy34"}, {31'd0, bus.busy}, 32'd0);
      $display("op %s a=%h b=%h -> hi=%h lo=%h dbz=%0d", name, a, b, bus.hi, bus.lo, bus.dbz);
      cyc();
   endtask

   initial begin
      bus.start   = 1'b0;
      bus.op      = 2'd0;
      bus.a       = 32'd0;
      bus.b       = 32'd0;
      bus.flush   = 1'b0;
      bus.rd_hilo = 1'b0;
      bus.hi_we   = 1'b0;
      bus.lo_we   = 1'b0;
      bus.wd      = 32'd0;

      // reset state
      repeat (3) cyc();
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      rst = 1'b1;
      cyc();

      // directed arithmetic vectors
      run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      run_op("mult_min2", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      run_op("mult_7xm1", 2'b01, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0);
      run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("div_7dm2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
      run_op("divu_100d7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run_op("divu_big", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1, 1'b0);
      run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
      run_op("divu_dbz", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
      run_op("div_dbz", 2'b11, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);

      // direct writes in IDLE
      bus.hi_we = 1'b1;
      bus.wd    = 32'hA5A5_0001;
      cyc();
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b1;
      bus.wd    = 32'hA5A5_0002;
      chk("mthi", bus.hi, 32'hA5A5_0001);
      cyc();
      bus.lo_we = 1'b0;
      chk("mtlo", bus.lo, 32'hA5A5_0002);
      $display("direct write hi=%h lo=%h", bus.hi, bus.lo);

      // flush mid-RUN: no done, HI/LO kept
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd4;
      cyc();
      bus.start = 1'b0;
      repeat (9) cyc();               // cycle 10
      bus.flush = 1'b1;
      cyc();                          // cycle 11
      bus.flush = 1'b0;
      chk("flush_busy", {31'd0, bus.busy}, 32'd0);
      repeat (30) cyc();
      chk("flush_hi", bus.hi, 32'hA5A5_0001);
      chk("flush_lo", bus.lo, 32'hA5A5_0002);
      $display("flush at cycle 10 -> hi=%h lo=%h", bus.hi, bus.lo);

      // start and mthi while busy are ignored, stall raised
      bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd10;
      cyc();
      bus.start = 1'b0;
      repeat (4) cyc();               // cycle 5
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd5;
      bus.hi_we = 1'b1; bus.wd = 32'hDEAD_BEEF;
      #1;
      chk("busy_stall", {31'd0, bus.stall}, 32'd1);
      cyc();
      bus.start = 1'b0; bus.hi_we = 1'b0;
      chk("busy_mthi_ign", bus.hi, 32'hA5A5_0001);
      repeat (28) cyc();              // cycle 34
      chk("busy_ign_lo", bus.lo, 32'd100);
      chk("busy_ign_hi", bus.hi, 32'd0);
      $display("ignored start: divu 1000/10 -> hi=%h lo=%h", bus.hi, bus.lo);
      cyc();

      // rd_hilo stall window, cycles 5..40
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd6; bus.b = 32'd7;
      cyc();
      bus.start = 1'b0;
      repeat (4) cyc();               // cycle 5
      bus.rd_hilo = 1'b1;
      #1;
      chk("rd_stall5", {31'd0, bus.stall}, 32'd1);
      repeat (28) cyc();              // cycle 33
      #1;
      chk("rd_stall33", {31'd0, bus.stall}, 32'd1);
      cyc();                          // cycle 34
      #1;
      chk("rd_stall34", {31'd0, bus.stall}, 32'd0);
      chk("rd_done34", {31'd0, bus.done}, 32'd1);
      chk("rd_lo", bus.lo, 32'd42);
      repeat (7) cyc();               // cycle 41
      bus.rd_hilo = 1'b0;
      $display("rd_hilo stall window -> lo=%h", bus.lo);
      cyc();

      // direct writes with an accepted start, later overridden by FIX
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd3;
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = 32'h0000_1234;
      cyc();
      bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      chk("wr_start_hi", bus.hi, 32'h0000_1234);
      chk("wr_start_lo", bus.lo, 32'h0000_1234);
      repeat (33) cyc();
      chk("wr_ovr_hi", bus.hi, 32'd0);
      chk("wr_ovr_lo", bus.lo, 32'd6);
      $display("write+start -> hi=%h lo=%h", bus.hi, bus.lo);
      cyc();

      // flush together with start in IDLE: start ignored
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd9;
      cyc();
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("flush_start_busy", {31'd0, bus.busy}, 32'd0);
      $display("flush+start in idle -> busy=%0d", bus.busy);
      repeat (3) cyc();

      // flush during FIX: no done, HI/LO unchanged
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd11; bus.b = 32'd11;
      cyc();
      bus.start = 1'b0;
      repeat (32) cyc();              // cycle 33
      bus.flush = 1'b1;
      cyc();                          // cycle 34
      bus.flush = 1'b0;
      chk("fixflush_done", {31'd0, bus.done}, 32'd0);
      chk("fixflush_lo", bus.lo, 32'd6);
      $display("flush in fix -> lo=%h done=%0d", bus.lo, bus.done);
      cyc();

      // asynchronous reset mid-operation
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'hFFFF_FFFF; bus.b = 32'd2;
      cyc();
      bus.start = 1'b0;
      repeat (19) cyc();              // cycle 20
      bus.rd_hilo = 1'b1;
      rst = 1'b0;
      #1;
      chk("arst_hi", bus.hi, 32'd0);
      chk("arst_lo", bus.lo, 32'd0);
      chk("arst_busy", {31'd0, bus.busy}, 32'd0);
      chk("arst_done", {31'd0, bus.done}, 32'd0);
      chk("arst_dbz", {31'd0, bus.dbz}, 32'd0);
      chk("arst_stall", {31'd0, bus.stall}, 32'd0);
      $display("reset at cycle 20 -> hi=%h lo=%h busy=%0d", bus.hi, bus.lo, bus.busy);
      cyc();
      bus.rd_hilo = 1'b0;
      rst = 1'b1;
      cyc();
      run_op("post_rst", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);

      repeat (2) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
